tdm_demux8_8: RTL and testbench

- Time-division demultiplexer: the receiving end of an 8-way 8-bit channel multiplexer.
- Accepts a serial stream of 8-bit beats over a valid/ready handshake. Slot 0 is marked by start-of-frame.
- Reassembles each 8-beat frame into 8 parallel channel bytes, published as one bank with a valid/ack handshake.
- Sits between the time-multiplexed datapath and the per-channel consumers (display/LED/register banks).

---
 rtl/tdm_demux8_8_pkg.sv | 15 +
 rtl/tdm_slot_ctrl.sv | 68 ++++++
 rtl/tdm_demux8_8.sv | 87 ++++++++
 tb/tb_tdm_demux8_8.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux8_8_pkg.sv
// Shared constants and state encoding for the 8-way TDM demultiplexer.
package tdm_demux8_8_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned W      = 8;
  localparam int unsigned SLOT_W = 3;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Slot sequencing for the TDM demux: framing state, slot counter, SOF checks,
// input backpressure, one-hot shadow write enables and the publish strobe.
module tdm_slot_ctrl
  import tdm_demux8_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              out_valid,
  input  logic              out_ack,
  output logic              in_ready,
  output logic [SLOT_W-1:0] slot,
  output logic              sof_err,
  output logic [N-1:0]      wr_en,
  output logic              publish
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              sof_err_q, sof_err_d;
  logic              fire;

  // Hold the final beat while the previous frame is still unconsumed.
  assign in_ready = !((state_q == StFill) && (slot_q == LAST_SLOT) && out_valid && !out_ack);
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    sof_err_d = 1'b0;
    wr_en     = '0;
    publish   = 1'b0;
    if (fire) begin
      if (in_sof) begin
        wr_en[0]  = 1'b1;
        slot_d    = 3'd1;
        state_d   = StFill;
        sof_err_d = (state_q == StFill);
      end else if (state_q == StIdle) begin
        sof_err_d = 1'b1;
      end else begin
        wr_en  = N'(1) << slot_q;
        slot_d = slot_q + 3'd1;
        if (slot_q == LAST_SLOT) begin
          publish = 1'b1;
          state_d = StIdle;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign slot    = slot_q;
  assign sof_err = sof_err_q;

endmodule

// File: rtl/tdm_demux8_8.sv
// 8-way 8-bit TDM demultiplexer: collects 8 serial beats into a shadow bank
// and publishes them as one 64-bit frame with a valid/ack handshake.
module tdm_demux8_8
  import tdm_demux8_8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_sof,
  output logic [W*N-1:0]    out_bank,
  output logic              out_valid,
  input  logic              out_ack,
  output logic [SLOT_W-1:0] slot,
  output logic              sof_err,
  output logic [7:0]        frame_cnt
);

  logic [N-1:0]   wr_en;
  logic           publish;
  logic           unused_wr_last;
  logic [W-1:0]   shadow_q [N-1];
  logic [W-1:0]   shadow_d [N-1];
  logic [W*N-1:0] out_bank_q, out_bank_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;

  tdm_slot_ctrl u_slot_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .out_valid (out_valid_q),
    .out_ack   (out_ack),
    .in_ready  (in_ready),
    .slot      (slot),
    .sof_err   (sof_err),
    .wr_en     (wr_en),
    .publish   (publish)
  );

  // The last slot bypasses the shadow bank and goes straight into out_bank.
  assign unused_wr_last = wr_en[N-1];

  always_comb begin
    for (int unsigned k = 0; k < N - 1; k++) begin
      shadow_d[k] = wr_en[k] ? in_data : shadow_q[k];
    end
    out_bank_d  = out_bank_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (publish) begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        out_bank_d[W*k +: W] = shadow_q[k];
      end
      out_bank_d[W*(N-1) +: W] = in_data;
      out_valid_d              = 1'b1;
      frame_cnt_d              = frame_cnt_q + 8'd1;
    end else if (out_ack && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        shadow_q[k] <= '0;
      end
      out_bank_q  <= '0;
      out_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N - 1; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
      out_bank_q  <= out_bank_d;
      out_valid_q <= out_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_bank  = out_bank_q;
  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux8_8.sv
// Directed bench for tdm_demux8_8: framing, backpressure, async reset, wrap.
module tb_tdm_demux8_8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic [63:0] out_bank;
  logic        out_valid;
  logic        out_ack;
  logic [2:0]  slot;
  logic        sof_err;
  logic [7:0]  frame_cnt;

  int tests = 0;
  int fails = 0;
  logic sof_seen;

  tdm_demux8_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_bank  (out_bank),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .slot      (slot),
    .sof_err   (sof_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for in_ready, transfer it, return #1 after the edge.
  task automatic beat(input logic [7:0] d, input logic s);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (sof_err) sof_seen = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0]  fb [8];
  logic [63:0] exp_bank;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sof   = 1'b0;
    out_ack  = 1'b0;
    sof_seen = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_slot", {61'd0, slot}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_bank", out_bank, 64'd0);
    check("rst_cnt", {56'd0, frame_cnt}, 64'd0);
    check("rst_err", {63'd0, sof_err}, 64'd0);
    check("rst_ready", {63'd0, in_ready}, 64'd1);

    // 1. Basic frame, back-to-back beats
    beat(8'h10, 1'b1);
    check("t1_slot1", {61'd0, slot}, 64'd1);
    for (int k = 1; k < 8; k++) beat(8'h10 + 8'(k), 1'b0);
    check("t1_bank", out_bank, 64'h1716151413121110);
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_cnt", {56'd0, frame_cnt}, 64'd1);
    check("t1_slot", {61'd0, slot}, 64'd0);

    // Consume it
    out_ack = 1'b1;
    idle(1);
    out_ack = 1'b0;
    check("ack_valid", {63'd0, out_valid}, 64'd0);
    check("ack_bank", out_bank, 64'h1716151413121110);

    // 2. Framing errors
    beat(8'hAA, 1'b0);
    check("t2_err_drop", {63'd0, sof_err}, 64'd1);
    check("t2_slot_drop", {61'd0, slot}, 64'd0);
    beat(8'h20, 1'b1);
    check("t2_err_clr", {63'd0, sof_err}, 64'd0);
    beat(8'h21, 1'b0);
    beat(8'h22, 1'b0);
    check("t2_slot3", {61'd0, slot}, 64'd3);
    beat(8'h30, 1'b1);
    check("t2_err_restart", {63'd0, sof_err}, 64'd1);
    check("t2_slot_restart", {61'd0, slot}, 64'd1);
    check("t2_valid_none", {63'd0, out_valid}, 64'd0);
    for (int k = 1; k < 8; k++) beat(8'h30 + 8'(k), 1'b0);
    check("t2_bank", out_bank, 64'h3736353433323130);
    check("t2_cnt", {56'd0, frame_cnt}, 64'd2);

    // 3. Backpressure on the final beat
    beat(8'h40, 1'b1);
    for (int k = 1; k < 7; k++) beat(8'h40 + 8'(k), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h47;
    idle(3);
    check("t3_ready", {63'd0, in_ready}, 64'd0);
    check("t3_slot", {61'd0, slot}, 64'd7);
    check("t3_bank_held", out_bank, 64'h3736353433323130);
    check("t3_cnt_held", {56'd0, frame_cnt}, 64'd2);
    out_ack = 1'b1;
    #1;
    check("t3_ready_ack", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    out_ack  = 1'b0;
    in_valid = 1'b0;
    check("t3_bank", out_bank, 64'h4746454443424140);
    check("t3_valid", {63'd0, out_valid}, 64'd1);
    check("t3_cnt", {56'd0, frame_cnt}, 64'd3);
    check("t3_slot0", {61'd0, slot}, 64'd0);

    // 4. Ack coincident with publish
    beat(8'h50, 1'b1);
    for (int k = 1; k < 7; k++) beat(8'h50 + 8'(k), 1'b0);
    out_ack = 1'b1;
    beat(8'h57, 1'b0);
    out_ack = 1'b0;
    check("t4_valid", {63'd0, out_valid}, 64'd1);
    check("t4_bank", out_bank, 64'h5756555453525150);
    check("t4_cnt", {56'd0, frame_cnt}, 64'd4);

    // 5. Asynchronous reset mid-frame
    beat(8'h60, 1'b1);
    for (int k = 1; k < 4; k++) beat(8'h60 + 8'(k), 1'b0);
    check("t5_slot4", {61'd0, slot}, 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_slot", {61'd0, slot}, 64'd0);
    check("t5_valid", {63'd0, out_valid}, 64'd0);
    check("t5_bank", out_bank, 64'd0);
    check("t5_cnt", {56'd0, frame_cnt}, 64'd0);
    #2;
    rst_n = 1'b1;
    idle(1);
    beat(8'h70, 1'b1);
    for (int k = 1; k < 8; k++) beat(8'h70 + 8'(k), 1'b0);
    check("t5_bank_after", out_bank, 64'h7776757473727170);
    check("t5_cnt_after", {56'd0, frame_cnt}, 64'd1);

    // 6. 256 frames with random gaps and immediate acks
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(1);
    out_ack  = 1'b1;
    sof_seen = 1'b0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      exp_bank = {fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1], fb[0]};
      for (int k = 0; k < 8; k++) begin
        idle($urandom_range(0, 2));
        beat(fb[k], k == 0);
      end
      check("t6_bank", out_bank, exp_bank);
      check("t6_valid", {63'd0, out_valid}, 64'd1);
      if (f == 254) check("t6_cnt255", {56'd0, frame_cnt}, 64'd255);
    end
    out_ack = 1'b0;
    check("t6_cnt_wrap", {56'd0, frame_cnt}, 64'd0);
    check("t6_no_err", {63'd0, sof_seen}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
